ctrl_pipe: RTL and testbench

Control-signal pipeline that takes the decode-stage control word from the main controller and carries it through the Execute, Memory and Writeback stages of the five-stage RISC-V core. It resolves branches and jumps in Execute by producing PCSrcE, and it inserts bubbles on flush or stall. It is the sequential stage directly downstream of the decode controller. The hazard unit and datapath consume its E/M/W outputs.

---
 rtl/ctrl_pipe_if.sv | 65 ++++++
 rtl/ctrl_pipe.sv | 147 ++++++++++++++
 tb/tb_ctrl_pipe.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_if.sv
// Control-word bus between the decode controller, hazard unit and ctrl_pipe.
// TakenCnt/BubbleCnt exist only when CTRL_PERFCNT_EN is defined.
interface ctrl_pipe_if #(
    parameter int CNT_W = 16
);
    // Decode-stage control word
    logic       RegWriteD;
    logic [1:0] ResultSrcD;
    logic       MemWriteD;
    logic       JumpD;
    logic       BranchD;
    logic [2:0] ALUControlD;
    logic       ALUSrcD;
    logic [2:0] funct3D;

    // Hazard-unit controls and ALU flags from the datapath
    logic       FlushE;
    logic       StallE;
    logic       ZeroE;
    logic       LtE;

    // Execute stage
    logic       RegWriteE;
    logic [1:0] ResultSrcE;
    logic       MemWriteE;
    logic [2:0] ALUControlE;
    logic       ALUSrcE;
    logic       PCSrcE;

    // Memory and Writeback stages
    logic       RegWriteM;
    logic [1:0] ResultSrcM;
    logic       MemWriteM;
    logic       RegWriteW;
    logic [1:0] ResultSrcW;

`ifdef CTRL_PERFCNT_EN
    logic [CNT_W-1:0] TakenCnt;
    logic [CNT_W-1:0] BubbleCnt;
`endif

    modport master (
`ifdef CTRL_PERFCNT_EN
        input  TakenCnt, BubbleCnt,
`endif
        output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
               ALUControlD, ALUSrcD, funct3D,
               FlushE, StallE, ZeroE, LtE,
        input  RegWriteE, ResultSrcE, MemWriteE, ALUControlE, ALUSrcE, PCSrcE,
               RegWriteM, ResultSrcM, MemWriteM,
               RegWriteW, ResultSrcW
    );

    modport slave (
`ifdef CTRL_PERFCNT_EN
        output TakenCnt, BubbleCnt,
`endif
        input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
               ALUControlD, ALUSrcD, funct3D,
               FlushE, StallE, ZeroE, LtE,
        output RegWriteE, ResultSrcE, MemWriteE, ALUControlE, ALUSrcE, PCSrcE,
               RegWriteM, ResultSrcM, MemWriteM,
               RegWriteW, ResultSrcW
    );
endinterface

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control word through E/M/W and resolves branches in E.
// Define CTRL_PERFCNT_EN to add saturating TakenCnt/BubbleCnt performance counters.
module ctrl_pipe #(
    parameter int CNT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
        logic       jump;
        logic       branch;
        logic [2:0] alu_control;
        logic       alu_src;
        logic [2:0] funct3;
    } e_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
        logic       mem_write;
    } m_ctrl_t;

    typedef struct packed {
        logic       reg_write;
        logic [1:0] result_src;
    } w_ctrl_t;

    e_ctrl_t r_e;
    m_ctrl_t r_m;
    w_ctrl_t r_w;

    e_ctrl_t w_d;
    m_ctrl_t w_m_next;
    logic    w_cond;
    logic    w_pcsrc;

    assign w_d = '{
        reg_write:   bus.RegWriteD,
        result_src:  bus.ResultSrcD,
        mem_write:   bus.MemWriteD,
        jump:        bus.JumpD,
        branch:      bus.BranchD,
        alu_control: bus.ALUControlD,
        alu_src:     bus.ALUSrcD,
        funct3:      bus.funct3D
    };

    // Flush has priority over stall: the stalled word is discarded and M still receives it.
    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_e <= '0;
        end else if (bus.FlushE) begin
            r_e <= '0;
        end else if (!bus.StallE) begin
            r_e <= w_d;
        end
    end

    // A stall without a flush pushes a bubble into M while E holds.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        w_m_next = '{reg_write: r_e.reg_write, result_src: r_e.result_src, mem_write: r_e.mem_write};
        if (bus.StallE && !bus.FlushE) begin
            w_m_next = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_m <= '0;
        end else begin
            r_m <= w_m_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w <= '0;
        end else begin
            r_w <= '{reg_write: r_m.reg_write, result_src: r_m.result_src};
        end
    end

    always_comb begin
        w_cond = 1'b0;
        case (r_e.funct3)
            F3_BEQ:  w_cond = bus.ZeroE;
            F3_BNE:  w_cond = ~bus.ZeroE;
            F3_BLT:  w_cond = bus.LtE;
            F3_BGE:  w_cond = ~bus.LtE;
            default: w_cond = 1'b0;
        endcase
    end

    // Masked during a stall so the redirect fires exactly once, on the unstalled cycle.
    assign w_pcsrc = ~bus.StallE & (r_e.jump | (r_e.branch & w_cond));

    assign bus.RegWriteE   = r_e.reg_write;
    assign bus.ResultSrcE  = r_e.result_src;
    assign bus.MemWriteE   = r_e.mem_write;
    assign bus.ALUControlE = r_e.alu_control;
    assign bus.ALUSrcE     = r_e.alu_src;
    assign bus.PCSrcE      = w_pcsrc;

    assign bus.RegWriteM   = r_m.reg_write;
    assign bus.ResultSrcM  = r_m.result_src;
    assign bus.MemWriteM   = r_m.mem_write;

    assign bus.RegWriteW   = r_w.reg_write;
    assign bus.ResultSrcW  = r_w.result_src;

`ifdef CTRL_PERFCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_taken_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_pcsrc && (r_taken_cnt != CNT_MAX)) begin
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            end
            if ((bus.FlushE || bus.StallE) && (r_bubble_cnt != CNT_MAX)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.TakenCnt  = r_taken_cnt;
    assign bus.BubbleCnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus random traffic against an instruction-flow model.
// Builds with or without CTRL_PERFCNT_EN; the counter checks follow the macro.
module tb_ctrl_pipe;

`ifdef CTRL_PERFCNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 16;
`endif
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ctrl_pipe_if #(.CNT_W(CNT_W)) bus ();
    ctrl_pipe #(.CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    // One instruction's control word, tracked as it moves from slot to slot
    typedef struct {
        bit       rw;
        bit [1:0] rs;
        bit       mw;
        bit       j;
        bit       b;
        bit [2:0] alu;
        bit       as;
        bit [2:0] f3;
    } instr_t;

    instr_t in_e, in_m, in_w;
    int unsigned taken_cnt, bubble_cnt;
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic instr_t bubble();
        instr_t z;
        z = '{default: 0};
        return z;
    endfunction

    // Branch outcome straight from the mnemonic table
    function automatic bit branch_taken(input bit [2:0] f3, input bit zero, input bit lt);
        case (f3)
            3'd0:    return zero;      // beq
            3'd1:    return !zero;     // bne
            3'd4:    return lt;        // blt
            3'd5:    return !lt;       // bge
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit exp_pcsrc();
        if (rst || bus.StallE) return 1'b0;
        return in_e.j || (in_e.b && branch_taken(in_e.f3, bus.ZeroE, bus.LtE));
    endfunction

    task automatic model_reset();
        in_e = bubble();
        in_m = bubble();
        in_w = bubble();
        taken_cnt  = 0;
        bubble_cnt = 0;
    endtask

    // Advance the instruction slots by one clock edge
    task automatic model_clock();
        instr_t d;
        if (rst) begin
            model_reset();
            return;
        end
        if (exp_pcsrc() && taken_cnt < CNT_MAX) taken_cnt++;
        if ((bus.FlushE || bus.StallE) && bubble_cnt < CNT_MAX) bubble_cnt++;
        d = '{bus.RegWriteD, bus.ResultSrcD, bus.MemWriteD, bus.JumpD, bus.BranchD,
              bus.ALUControlD, bus.ALUSrcD, bus.funct3D};
        in_w = in_m;
        if (bus.StallE && !bus.FlushE) in_m = bubble();
        else                           in_m = in_e;
        if (bus.FlushE)        in_e = bubble();
        else if (!bus.StallE)  in_e = d;
    endtask

    task automatic check_all();
        check("E.RegWrite",   bus.RegWriteE,   in_e.rw);
        check("E.ResultSrc",  bus.ResultSrcE,  in_e.rs);
        check("E.MemWrite",   bus.MemWriteE,   in_e.mw);
        check("E.ALUControl", bus.ALUControlE, in_e.alu);
        check("E.ALUSrc",     bus.ALUSrcE,     in_e.as);
        check("E.PCSrc",      bus.PCSrcE,      exp_pcsrc());
        check("M.RegWrite",   bus.RegWriteM,   in_m.rw);
        check("M.ResultSrc",  bus.ResultSrcM,  in_m.rs);
        check("M.MemWrite",   bus.MemWriteM,   in_m.mw);
        check("W.RegWrite",   bus.RegWriteW,   in_w.rw);
        check("W.ResultSrc",  bus.ResultSrcW,  in_w.rs);
`ifdef CTRL_PERFCNT_EN
        check("TakenCnt",     bus.TakenCnt,    taken_cnt);
        check("BubbleCnt",    bus.BubbleCnt,   bubble_cnt);
`endif
    endtask

    task automatic set_d(input bit rw, input bit [1:0] rs, input bit mw, input bit j,
                         input bit b, input bit [2:0] alu, input bit as, input bit [2:0] f3);
        bus.RegWriteD   = rw;
        bus.ResultSrcD  = rs;
        bus.MemWriteD   = mw;
        bus.JumpD       = j;
        bus.BranchD     = b;
        bus.ALUControlD = alu;
        bus.ALUSrcD     = as;
        bus.funct3D     = f3;
    endtask

    task automatic set_h(input bit flush, input bit stall, input bit zero, input bit lt);
        bus.FlushE = flush;
        bus.StallE = stall;
        bus.ZeroE  = zero;
        bus.LtE    = lt;
    endtask

    // One clock edge: model follows the DUT, then return at the falling edge
    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic settle_check();
        #1;
        check_all();
    endtask

    // Asynchronous reset pulse placed between edges; called at a falling edge
    task automatic pulse_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        set_h(0, 0, 0, 0);
        model_reset();
        @(negedge clk);
        settle_check();
        rst = 1'b0;

        // Fill the pipe with nonzero words, then reset asynchronously between edges
        set_d(1, 2'b10, 1, 1, 0, 3'd6, 1, 3'd0);
        repeat (3) step();
        settle_check();
        rst = 1'b1;
        #1;
        check("rst_async.RegWriteE", bus.RegWriteE, 0);
        check("rst_async.MemWriteM", bus.MemWriteM, 0);
        check("rst_async.RegWriteW", bus.RegWriteW, 0);
        check("rst_async.PCSrcE",    bus.PCSrcE,    0);
        model_reset();
        check_all();
        #1;
        rst = 1'b0;

        // Latency after release
        set_d(1, 2'b01, 0, 0, 0, 0, 0, 0);
        step();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        settle_check();
        check("lat.RegWriteE", bus.RegWriteE, 1);
        step();
        settle_check();
        check("lat.RegWriteM",  bus.RegWriteM,  1);
        check("lat.ResultSrcM", bus.ResultSrcM, 2'b01);
        step();
        settle_check();
        check("lat.RegWriteW",  bus.RegWriteW,  1);
        check("lat.ResultSrcW", bus.ResultSrcW, 2'b01);

        // Branch decode
        set_d(0, 0, 0, 0, 1, 0, 0, 3'b001);
        step();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        set_h(0, 0, 0, 0);
        #1;
        check("bne.taken", bus.PCSrcE, 1);
        bus.ZeroE = 1'b1;
        #1;
        check("bne.not_taken", bus.PCSrcE, 0);
        check_all();
        set_d(0, 0, 0, 0, 1, 0, 0, 3'b101);
        step();
        set_d(0, 0, 0, 0, 1, 0, 0, 3'b010);
        set_h(0, 0, 0, 1);
        #1;
        check("bge.lt_not_taken", bus.PCSrcE, 0);
        step();
        for (int k = 0; k < 4; k++) begin
            bus.ZeroE = k[0];
            bus.LtE   = k[1];
            #1;
            check("f3_010.never", bus.PCSrcE, 0);
        end
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        set_h(0, 0, 0, 0);
        step();

        // Jump: redirect for one cycle, hazard unit answers with FlushE
        set_d(1, 2'b10, 0, 1, 0, 0, 0, 0);
        step();
        set_d(1, 0, 1, 0, 0, 3'd2, 1, 0);
        #1;
        check("jump.PCSrcE", bus.PCSrcE, 1);
        bus.FlushE = exp_pcsrc();
        settle_check();
        step();
        bus.FlushE = 1'b0;
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("jump.flush.RegWriteE", bus.RegWriteE, 0);
        check("jump.flush.MemWriteE", bus.MemWriteE, 0);
        check("jump.flush.PCSrcE",    bus.PCSrcE,    0);
        step();

        // Stall for two cycles with a store-and-jump word held in E
        set_d(0, 0, 1, 1, 0, 0, 0, 0);
        step();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        bus.StallE = 1'b1;
        #1;
        check("stall.MemWriteE", bus.MemWriteE, 1);
        check("stall.PCSrcE",    bus.PCSrcE,    0);
        step();
        #1;
        check("stall1.MemWriteE", bus.MemWriteE, 1);
        check("stall1.MemWriteM", bus.MemWriteM, 0);
        check("stall1.PCSrcE",    bus.PCSrcE,    0);
        step();
        bus.StallE = 1'b0;
        #1;
        check("stall2.MemWriteE", bus.MemWriteE, 1);
        check("stall2.MemWriteM", bus.MemWriteM, 0);
        check("release.PCSrcE",   bus.PCSrcE,    1);
        step();
        settle_check();
        check("release.MemWriteM", bus.MemWriteM, 1);
        check("release.MemWriteE", bus.MemWriteE, 0);

        // Flush and stall together: E bubbles, M gets the old E word
        set_d(1, 2'b10, 1, 0, 0, 3'd5, 1, 0);
        step();
        set_d(1, 2'b01, 0, 0, 0, 3'd1, 0, 0);
        set_h(1, 1, 0, 0);
        step();
        set_h(0, 0, 0, 0);
        settle_check();
        check("fs.RegWriteE",  bus.RegWriteE,  0);
        check("fs.RegWriteM",  bus.RegWriteM,  1);
        check("fs.ResultSrcM", bus.ResultSrcM, 2'b10);
        check("fs.MemWriteM",  bus.MemWriteM,  1);

`ifdef CTRL_PERFCNT_EN
        pulse_reset();
        set_d(0, 0, 0, 1, 0, 0, 0, 0);
        repeat (20) step();
        settle_check();
        check("perf.TakenCnt_sat", bus.TakenCnt, CNT_MAX);
        pulse_reset();
        set_d(0, 0, 0, 0, 0, 0, 0, 0);
        bus.FlushE = 1'b1;
        repeat (3) step();
        bus.FlushE = 1'b0;
        settle_check();
        check("perf.BubbleCnt3", bus.BubbleCnt, 3);
        pulse_reset();
        check("perf.rst.TakenCnt",  bus.TakenCnt,  0);
        check("perf.rst.BubbleCnt", bus.BubbleCnt, 0);
`endif

        // Random traffic with sporadic flushes, stalls and resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(49) == 0) pulse_reset();
            set_d($urandom_range(1), 2'($urandom_range(3)), $urandom_range(1), ($urandom_range(5) == 0),
                  $urandom_range(1), 3'($urandom_range(7)), $urandom_range(1), 3'($urandom_range(7)));
            set_h(($urandom_range(7) == 0), ($urandom_range(5) == 0), $urandom_range(1), $urandom_range(1));
            settle_check();
            step();
        end
        set_h(0, 0, 0, 0);
        settle_check();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
